// File: rtl/lcd_ctrl.sv
// lcd_ctrl: turns LSU LCD register writes into timed HD44780 bus cycles.
// Runs the power-up init sequence, queues software transfers and reports a status word.
module lcd_ctrl #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned T_POWERUP  = 750000,
    parameter int unsigned T_SETUP    = 2,
    parameter int unsigned T_PULSE    = 12,
    parameter int unsigned T_HOLD     = 2,
    parameter int unsigned T_EXEC     = 2000,
    parameter int unsigned T_CLEAR    = 82000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_io_lcd,
    output logic        o_lcd_on,
    output logic        o_lcd_en,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic [7:0]  o_lcd_data,
    output logic [31:0] o_status
);

    localparam int unsigned TMAX_A  = (T_POWERUP > T_CLEAR) ? T_POWERUP : T_CLEAR;
    localparam int unsigned TMAX_B  = (T_EXEC > T_PULSE) ? T_EXEC : T_PULSE;
    localparam int unsigned TMAX_C  = (T_SETUP > T_HOLD) ? T_SETUP : T_HOLD;
    localparam int unsigned TMAX_AB = (TMAX_A > TMAX_B) ? TMAX_A : TMAX_B;
    localparam int unsigned TMAX    = (TMAX_AB > TMAX_C) ? TMAX_AB : TMAX_C;
    localparam int unsigned CW      = $clog2(TMAX) + 1;
    localparam int unsigned AW      = $clog2(FIFO_DEPTH);
    localparam int unsigned NW      = AW + 1;

    localparam logic [2:0] StPwrup = 3'd0;
    localparam logic [2:0] StInit  = 3'd1;
    localparam logic [2:0] StIdle  = 3'd2;
    localparam logic [2:0] StSetup = 3'd3;
    localparam logic [2:0] StPulse = 3'd4;
    localparam logic [2:0] StHold  = 3'd5;
    localparam logic [2:0] StWait  = 3'd6;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic          init_done_q, init_done_d;
    logic          ovf_q, ovf_d;
    logic          go_q;
    logic          rs_q, rs_d;
    logic [7:0]    data_q, data_d;
    logic          en_q;
    logic          on_q;
    logic [31:0]   status_q, status_d;

    logic [8:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [NW-1:0] count_q, count_d;

    logic          push_req, push, pop, full, empty;
    logic          tdone, clear_cmd;
    logic [31:0]   limit;
    logic [8:0]    head;
    logic          unused_io;

    assign unused_io = ^i_io_lcd[29:9];

    function automatic logic [7:0] init_byte(input logic [1:0] k);
        logic [7:0] b;
        case (k)
            2'd0:    b = 8'h38;
            2'd1:    b = 8'h0C;
            2'd2:    b = 8'h06;
            default: b = 8'h01;
        endcase
        return b;
    endfunction

    // Transfer queue; a pop in the same cycle frees the slot a full-queue push needs.
    assign empty    = (count_q == '0);
    assign full     = (count_q == NW'(FIFO_DEPTH));
    assign pop      = (state_q == StIdle) && !empty;
    assign push_req = i_io_lcd[30] ^ go_q;
    assign push     = push_req && (!full || pop);
    assign head     = mem[rd_ptr_q];
    assign ovf_d    = ovf_q | (push_req & ~push);

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + NW'(1);
        end else if (pop && !push) begin
            count_d = count_q - NW'(1);
        end
    end

    // Clear/home commands need the long post-transfer wait.
    assign clear_cmd = !rs_q && ((data_q == 8'h01) || (data_q == 8'h02));

    always_comb begin
        case (state_q)
            StPwrup: limit = T_POWERUP;
            StSetup: limit = T_SETUP;
            StPulse: limit = T_PULSE;
            StHold:  limit = T_HOLD;
            StWait:  limit = clear_cmd ? T_CLEAR : T_EXEC;
            default: limit = 32'd1;
        endcase
    end

    assign tdone = (cnt_q == CW'(limit - 32'd1));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CW'(1);
        idx_d       = idx_q;
        init_done_d = init_done_q;
        rs_d        = rs_q;
        data_d      = data_q;
        case (state_q)
            StPwrup: begin
                if (tdone) begin
                    state_d = StInit;
                    cnt_d   = '0;
                    idx_d   = 2'd0;
                    rs_d    = 1'b0;
                    data_d  = init_byte(2'd0);
                end
            end
            StInit: begin
                state_d = StSetup;
                cnt_d   = '0;
            end
            StIdle: begin
                cnt_d = '0;
                if (pop) begin
                    state_d = StSetup;
                    rs_d    = head[8];
                    data_d  = head[7:0];
                end
            end
            StSetup: begin
                if (tdone) begin
                    state_d = StPulse;
                    cnt_d   = '0;
                end
            end
            StPulse: begin
                if (tdone) begin
                    state_d = StHold;
                    cnt_d   = '0;
                end
            end
            StHold: begin
                if (tdone) begin
                    state_d = StWait;
                    cnt_d   = '0;
                end
            end
            StWait: begin
                if (tdone) begin
                    cnt_d = '0;
                    if (init_done_q) begin
                        state_d = StIdle;
                    end else if (idx_q == 2'd3) begin
                        init_done_d = 1'b1;
                        state_d     = StIdle;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = StInit;
                        rs_d    = 1'b0;
                        data_d  = init_byte(idx_q + 2'd1);
                    end
                end
            end
            default: begin
                state_d = StPwrup;
                cnt_d   = '0;
            end
        endcase
    end

    // Status is registered from next-state values so it tracks the FSM with no lag.
    always_comb begin
        status_d       = '0;
        status_d[31]   = (state_d != StIdle) || (count_d != '0);
        status_d[30]   = ovf_d;
        status_d[29]   = init_done_d;
        status_d[4:0]  = 5'(count_d);
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q     <= StPwrup;
            cnt_q       <= '0;
            idx_q       <= 2'd0;
            init_done_q <= 1'b0;
            ovf_q       <= 1'b0;
            go_q        <= i_io_lcd[30];
            rs_q        <= 1'b0;
            data_q      <= 8'h00;
            en_q        <= 1'b0;
            on_q        <= 1'b0;
            status_q    <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            init_done_q <= init_done_d;
            ovf_q       <= ovf_d;
            go_q        <= i_io_lcd[30];
            rs_q        <= rs_d;
            data_q      <= data_d;
            en_q        <= (state_d == StPulse);
            on_q        <= i_io_lcd[31];
            status_q    <= status_d;
            count_q     <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset && push) begin
            mem[wr_ptr_q] <= i_io_lcd[8:0];
        end
    end

    assign o_lcd_on   = on_q;
    assign o_lcd_en   = en_q;
    assign o_lcd_rs   = rs_q;
    assign o_lcd_rw   = 1'b0;
    assign o_lcd_data = data_q;
    assign o_status   = status_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Bench for lcd_ctrl: transfer-timeline reference model compared every cycle,
// plus hand-computed pulse times, ordering and wait lengths.
module tb_lcd_ctrl;

    localparam int DEPTH = 4;
    localparam int TPW   = 20;
    localparam int TSU   = 2;
    localparam int TPL   = 12;
    localparam int THD   = 2;
    localparam int TEX   = 10;
    localparam int TCL   = 30;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] io;
    logic        on, en, rs, rw;
    logic [7:0]  data;
    logic [31:0] status;

    int n_checks = 0;
    int n_errors = 0;

    lcd_ctrl #(
        .FIFO_DEPTH(DEPTH),
        .T_POWERUP (TPW),
        .T_SETUP   (TSU),
        .T_PULSE   (TPL),
        .T_HOLD    (THD),
        .T_EXEC    (TEX),
        .T_CLEAR   (TCL)
    ) dut (
        .i_clk     (clk),
        .i_reset   (rst_n),
        .i_io_lcd  (io),
        .o_lcd_on  (on),
        .o_lcd_en  (en),
        .o_lcd_rs  (rs),
        .o_lcd_rw  (rw),
        .o_lcd_data(data),
        .o_status  (status)
    );

    always #5 clk = ~clk;

    // Reference model: a transfer is a timeline of optional INIT cycle, setup, pulse,
    // hold and wait; mode 0 = power-up delay, 1 = transfer running, 2 = idle.
    logic [8:0] m_q[$];
    int         m_mode, m_pos, m_len, m_pre, m_idx;
    int         cyc;
    bit         m_init, m_ovf, m_done, m_rst, m_go, m_on;
    bit         m_valid = 1'b0;
    logic       m_rs;
    logic [7:0] m_data;

    function automatic int wait_len(input logic r, input logic [7:0] d);
        return (!r && (d == 8'h01 || d == 8'h02)) ? TCL : TEX;
    endfunction

    function automatic logic [7:0] init_seq(input int k);
        logic [7:0] t[4];
        t = '{8'h38, 8'h0C, 8'h06, 8'h01};
        return t[k];
    endfunction

    task automatic start_xfer(input logic r, input logic [7:0] d, input int pre);
        m_mode = 1;
        m_pos  = 0;
        m_pre  = pre;
        m_rs   = r;
        m_data = d;
        m_len  = pre + TSU + TPL + THD + wait_len(r, d);
    endtask

    task automatic model_step();
        bit         push;
        logic [8:0] e;
        if (!rst_n) begin
            m_mode = 0; m_pos = 0; m_q.delete();
            m_ovf = 0; m_done = 0; m_init = 0;
            m_rs = 1'b0; m_data = 8'h00; m_on = 0;
            m_go = io[30]; m_rst = 1; cyc = 0; m_valid = 1;
            return;
        end
        m_rst = 0;
        cyc++;
        m_on = io[31];
        push = (io[30] != m_go);
        m_go = io[30];
        case (m_mode)
            0: begin
                if (m_pos == TPW - 1) begin
                    m_init = 1; m_idx = 0;
                    start_xfer(1'b0, init_seq(0), 1);
                end else m_pos++;
            end
            1: begin
                if (m_pos == m_len - 1) begin
                    if (m_init && m_idx < 3) begin
                        m_idx++;
                        start_xfer(1'b0, init_seq(m_idx), 1);
                    end else begin
                        if (m_init) begin m_done = 1; m_init = 0; end
                        m_mode = 2;
                    end
                end else m_pos++;
            end
            default: begin
                if (m_q.size() > 0) begin
                    e = m_q.pop_front();
                    start_xfer(e[8], e[7:0], 0);
                end
            end
        endcase
        if (push) begin
            if (m_q.size() < DEPTH) m_q.push_back(io[8:0]);
            else m_ovf = 1;
        end
    endtask

    function automatic logic [43:0] model_out();
        logic        en_e, busy_e;
        logic [31:0] st;
        en_e   = (m_mode == 1) && (m_pos >= m_pre + TSU) && (m_pos < m_pre + TSU + TPL);
        busy_e = (m_mode != 2) || (m_q.size() != 0);
        st = '0;
        if (!m_rst) begin
            st[31]  = busy_e;
            st[30]  = m_ovf;
            st[29]  = m_done;
            st[4:0] = 5'(m_q.size());
        end
        return {m_on, en_e, m_rs, 1'b0, m_data, st};
    endfunction

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Per-cycle compare, plus a monitor recording EN rise times, data and widths.
    int         rise_cyc[$];
    logic [7:0] rise_dat[$];
    int         pulse_len[$];
    int         hi_len = 0;
    logic       en_prev = 1'b0;

    initial forever begin
        logic [43:0] exp_o, act_o;
        @(negedge clk);
        if (m_valid) begin
            exp_o = model_out();
            act_o = {on, en, rs, rw, data, status};
            n_checks++;
            if (act_o !== exp_o) begin
                n_errors++;
                $display("FAIL outputs @cyc %0d: got %h required %h", cyc, act_o, exp_o);
            end
        end
        if (en && !en_prev) begin
            rise_cyc.push_back(cyc);
            rise_dat.push_back(data);
            hi_len = 0;
        end
        if (en) hi_len++;
        if (!en && en_prev) pulse_len.push_back(hi_len);
        en_prev = en;
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        rise_cyc.delete();
        rise_dat.delete();
        pulse_len.delete();
    endtask

    task automatic toggle(input logic r, input logic [7:0] d);
        @(negedge clk);
        io[30]  = ~io[30];
        io[8]   = r;
        io[7:0] = d;
    endtask

    task automatic wait_idle(input int budget, output int at);
        int n;
        n = 0;
        @(negedge clk);
        while (status[31] && n < budget) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (status[31]) begin
            n_errors++;
            $display("FAIL idle_timeout: busy still 1 after %0d cycles, required 0", budget);
        end
        at = cyc;
    endtask

    task automatic check_pulses(input string tag, input int exp_cyc[$],
                                input logic [7:0] exp_dat[$]);
        check({tag, "_count"}, rise_cyc.size(), exp_cyc.size());
        for (int i = 0; i < exp_cyc.size(); i++) begin
            if (i < rise_cyc.size()) begin
                if (exp_cyc[i] >= 0) check({tag, "_rise"}, rise_cyc[i], exp_cyc[i]);
                check({tag, "_data"}, rise_dat[i], exp_dat[i]);
            end
        end
        foreach (pulse_len[i]) check({tag, "_width"}, pulse_len[i], TPL);
    endtask

    initial begin
        int         at, c;
        int         ec[$];
        logic [7:0] ed[$];

        io    = 32'h0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Power-up delay then four init commands; 0x01 gets the long wait.
        clear_mon();
        wait_idle(400, at);
        check("init_idle_cyc", at, 148);
        ec = '{23, 50, 77, 104};
        ed = '{8'h38, 8'h0C, 8'h06, 8'h01};
        check_pulses("init", ec, ed);
        check("init_done", status[29], 1);

        // Single data write; also turn the backlight on.
        @(negedge clk);
        io[31] = 1'b1;
        clear_mon();
        toggle(1'b1, 8'h41);
        c = cyc;
        wait_idle(200, at);
        check("data_elapsed", at - c, 28);
        ec = '{c + 4};
        ed = '{8'h41};
        check_pulses("data", ec, ed);
        check("lcd_on", on, 1);

        // Overflow: one transfer running, five pushes in a row, last one dropped.
        clear_mon();
        toggle(1'b1, 8'h60);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) toggle(1'b1, 8'(8'h50 + i));
        @(negedge clk);
        check("ovf_count", status[4:0], 4);
        check("ovf_flag", status[30], 1);
        wait_idle(400, at);
        ec = '{-1, -1, -1, -1, -1};
        ed = '{8'h60, 8'h50, 8'h51, 8'h52, 8'h53};
        check_pulses("ovf", ec, ed);
        check("ovf_sticky", status[30], 1);

        // Wait length depends on clear/home commands.
        toggle(1'b0, 8'h01);
        c = cyc;
        wait_idle(200, at);
        check("clear_elapsed", at - c, 48);
        @(negedge clk);
        io[31] = 1'b0;
        toggle(1'b1, 8'h01);
        c = cyc;
        wait_idle(200, at);
        check("rs1_01_elapsed", at - c, 28);
        io[31] = 1'b1;
        toggle(1'b0, 8'h02);
        c = cyc;
        wait_idle(200, at);
        check("home_elapsed", at - c, 48);

        // Reset in the middle of a pulse, then a write queued during power-up.
        toggle(1'b1, 8'h42);
        c = 0;
        while (!en && c < 20) begin
            @(negedge clk);
            c++;
        end
        check("pulse_seen", en, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_en", en, 0);
        check("rst_status", status, 0);
        rst_n = 1'b1;
        clear_mon();
        repeat (4) @(negedge clk);
        toggle(1'b1, 8'h77);
        wait_idle(400, at);
        check("rerun_idle_cyc", at, 175);
        ec = '{23, 50, 77, 104, 151};
        ed = '{8'h38, 8'h0C, 8'h06, 8'h01, 8'h77};
        check_pulses("rerun", ec, ed);
        check("rerun_ovf", status[30], 0);
        check("rerun_done", status[29], 1);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
